// File: rtl/tcpu_alu_seq.sv
// Registered ALU for the tiny CPU datapath: single-cycle logic/arith ops
// plus a WIDTH-cycle shift-add multiply sequenced by a two-state FSM.
module tcpu_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    // The last bit shifted out of a lands at bit WIDTH of the widened shift.
    shl_ext = {{WIDTH{1'b0}}, a} << b[SHW-1:0];

    alu_res   = a;
    alu_carry = 1'b0;
    case (op)
      OP_ADD:   begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB:   begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SHL:   begin
        alu_res   = shl_ext[WIDTH-1:0];
        alu_carry = (b[SHW-1:0] != '0) ? shl_ext[WIDTH] : 1'b0;
      end
      OP_PASSA: alu_res = a;
      default:  alu_res = a;
    endcase

    partial  = mplier_q[count_q] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
    acc_next = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d   = acc_next;
        count_d = count_q + SHW'(1);
        if (count_q == LAST_ITER) begin
          result_d = acc_next[WIDTH-1:0];
          carry_d  = |acc_next[2*WIDTH-1:WIDTH];
          zero_d   = (acc_next[WIDTH-1:0] == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule
